gpio_serial_loader: RTL and testbench
=====================================

# gpio_serial_loader

Serial programmer that sits directly upstream of the right-side GPIO pad block. It fetches per-pad control words from a config register port and shifts them down the pad control chain on `serial_data_out`/`serial_clock_out`. After the last bit it pulses `serial_load_out` so every pad latches its new configuration at the same time. One loader drives one chain, whose end is pad `NUM_PADS-1`.

## Interface
- `NUM_PADS`, default 15: number of pads on the chain.
- `PAD_CTRL_BITS`, default 12: control bits per pad.
- `CLK_DIV`, default 2: serial-clock half-period in `mclk` cycles; minimum 1.
- `AW`, default 4: config address width; must satisfy `2**AW >= NUM_PADS`.
- `mclk` input 1: single clock for the block.
- `reset` input 1: synchronous, active-high reset.
- `start` input 1: one-cycle request to load the whole chain.
- `busy` output 1: high while a sequence is in progress.
- `done` output 1: one-cycle pulse when a sequence completes.
- `cfg_rd_en` output 1: config read strobe.
- `cfg_rd_addr` output AW: pad index being fetched.
- `cfg_rd_data` input PAD_CTRL_BITS: config word, valid exactly one cycle after `cfg_rd_en`.
- `serial_clock_out` output 1: chain shift clock.
- `serial_data_out` output 1: chain serial data.
- `serial_load_out` output 1: chain load strobe.
- `serial_resetn_out` output 1: registered `~reset`, drives the chain's `resetn`.

## Operation
- All outputs are registered. Reset values: `busy`, `done`, `cfg_rd_en`, `serial_clock_out`, `serial_data_out`, `serial_load_out` = 0; `cfg_rd_addr` = 0; `serial_resetn_out` = 0.
- States and transitions:
  - IDLE → FETCH on `start`.
  - FETCH, 1 cycle: `cfg_rd_en`=1, `cfg_rd_addr`=current pad → CAPTURE.
  - CAPTURE, 1 cycle: `cfg_rd_data` goes into the shift register → SHIFT_LO.
  - SHIFT_LO, CLK_DIV cycles with clock low → SHIFT_HI.
  - SHIFT_HI, CLK_DIV cycles with clock high → SHIFT_LO for the next bit, or FETCH for the next pad, or SETTLE after the last bit.
  - SETTLE, CLK_DIV cycles low → LOAD.
  - LOAD, CLK_DIV cycles with `serial_load_out`=1 → DONE.
  - DONE, 1 cycle: `done`=1 → IDLE.
- Pad order is `NUM_PADS-1` down to 0, so the first word shifted ends up at the far end of the chain. Within a pad, bits go out MSB first.
- `serial_data_out` changes only on the first cycle of SHIFT_LO. It is stable across the rising edge of `serial_clock_out`.
- `start` while `busy` is ignored; no queuing.
- `cfg_rd_data` is sampled only in CAPTURE.
- Reset mid-sequence returns the block to IDLE. `serial_load_out` never asserts, so the pads keep their previously latched configuration. The chain shift register contents are then undefined until the next full load.
- Pad counter width is `$clog2(NUM_PADS)`. Bit counter width is `$clog2(PAD_CTRL_BITS)`. Phase counter width is `$clog2(CLK_DIV)+1`. All counters count down and must not wrap.

## Timing
- `busy` rises the cycle after `start` is sampled and falls with `done`.
- Busy length = `NUM_PADS*(2 + 2*CLK_DIV*PAD_CTRL_BITS) + 2*CLK_DIV + 1` cycles. With defaults this is 755.
- Each pad adds 2 dead cycles (FETCH, CAPTURE); `serial_clock_out` stays low during them.
- `serial_load_out` is high for exactly CLK_DIV cycles. It never overlaps a high `serial_clock_out`.
- `start` asserted in the same cycle as `done` is accepted: the block goes DONE → IDLE, then to FETCH on the next cycle.

## Configuration
- Macro `GPIO_LOADER_AUTOSTART_EN`.
- Defined: the first cycle after `reset` deasserts generates an internal start, so the chain loads once at power-up with no `start` pulse.
- Undefined: sequences begin only on `start`.

## Structure
- `gpio_loader_pkg` holds:
  - the state enum `gpio_ldr_state_t`;
  - default constants `GPIO_LDR_PAD_BITS=12` and `GPIO_LDR_NUM_PADS=15`.
- One sub-module, `gpio_loader_tick`: CLK_DIV phase counter producing a `phase_end` pulse, reloaded on every state entry.

## Test plan
- Defaults, word for pad p = `12'hC00 ^ p`, one `start`: a bench model of the 15-stage chain, latched on load, holds `12'hC00 ^ p` at pad p. Check `busy` = 755 cycles and exactly 180 rising edges on `serial_clock_out`.
- `CLK_DIV=1`, all words `12'hFFF` then `12'h000`: every pad latches the value from the latest load, and the clock high/low periods are 1 cycle each.
- `start` pulsed again at cycle 100 of a sequence: it is ignored and exactly one `done` pulse is seen.
- `reset` asserted at cycle 400: the next cycle shows `busy`=0 and `serial_clock_out`=0, `serial_load_out` never rose, and the model's latched values are unchanged.
- `start` in the same cycle as `done`: a second sequence begins two cycles later with `cfg_rd_addr`=14.
- With `GPIO_LOADER_AUTOSTART_EN` defined: `reset` released and no `start` → `cfg_rd_en` asserts 2 cycles after release with `cfg_rd_addr`=14, followed by one full sequence.

Source files
------------

// File: rtl/gpio_loader_pkg.sv
// Shared types and defaults for the GPIO pad-chain serial loader.
// Optional build macro used by the top: GPIO_LOADER_AUTOSTART_EN.
package gpio_loader_pkg;

  localparam int GPIO_LDR_PAD_BITS = 12;
  localparam int GPIO_LDR_NUM_PADS = 15;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_CAPTURE,
    ST_SHIFT_LO,
    ST_SHIFT_HI,
    ST_SETTLE,
    ST_LOAD,
    ST_DONE
  } gpio_ldr_state_t;

  // Counter width that stays legal when a count of one collapses $clog2 to zero.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/gpio_loader_tick.sv
// Serial-clock phase timer: reloads on every state entry, then counts
// CLK_DIV cycles down and flags the last cycle of the phase.
module gpio_loader_tick
  import gpio_loader_pkg::*;
#(
  parameter int CLK_DIV = 2
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_reload,
  output logic o_phase_end
);

  localparam int PW = $clog2(CLK_DIV) + 1;
  localparam logic [PW-1:0] RELOAD = PW'(CLK_DIV - 1);

  logic [PW-1:0] r_cnt;

  // Holds at zero rather than wrapping if a state outlives its phase.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (i_reload) begin
      r_cnt <= RELOAD;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_phase_end = (r_cnt == '0);

endmodule

// File: rtl/gpio_serial_loader.sv
// Fetches per-pad control words and shifts them down the pad chain, then pulses load.
// Build option GPIO_LOADER_AUTOSTART_EN: one automatic load right after reset release.
module gpio_serial_loader
  import gpio_loader_pkg::*;
#(
  parameter int NUM_PADS      = GPIO_LDR_NUM_PADS,
  parameter int PAD_CTRL_BITS = GPIO_LDR_PAD_BITS,
  parameter int CLK_DIV       = 2,
  parameter int AW            = 4
) (
  input  logic                     mclk,
  input  logic                     reset,
  input  logic                     start,
  output logic                     busy,
  output logic                     done,
  output logic                     cfg_rd_en,
  output logic [AW-1:0]            cfg_rd_addr,
  input  logic [PAD_CTRL_BITS-1:0] cfg_rd_data,
  output logic                     serial_clock_out,
  output logic                     serial_data_out,
  output logic                     serial_load_out,
  output logic                     serial_resetn_out
);

  localparam int PADW = cnt_w(NUM_PADS);
  localparam int BITW = cnt_w(PAD_CTRL_BITS);
  localparam int MSB  = PAD_CTRL_BITS - 1;
  localparam logic [PADW-1:0] PAD_LAST = PADW'(NUM_PADS - 1);
  localparam logic [BITW-1:0] BIT_LAST = BITW'(PAD_CTRL_BITS - 1);

  gpio_ldr_state_t          r_state, w_next;
  logic [PADW-1:0]          r_pad, w_pad_nxt;
  logic [BITW-1:0]          r_bit, w_bit_nxt;
  logic [PAD_CTRL_BITS-1:0] r_shift;
  logic                     r_pend;
  logic                     w_start, w_phase_end, w_reload, w_next_bit;
  logic                     r_busy, r_done, r_rd_en, r_sclk, r_sdat, r_load, r_resetn;
  logic [AW-1:0]            r_addr;

`ifdef GPIO_LOADER_AUTOSTART_EN
  // Fires in the first cycle the chain sees resetn high.
  logic [1:0] r_rst_pipe;
  always_ff @(posedge mclk) begin
    r_rst_pipe <= {r_rst_pipe[0], reset};
  end
  assign w_start = start | r_pend | (r_rst_pipe[1] & ~r_rst_pipe[0] & ~reset);
`else
  assign w_start = start | r_pend;
`endif

  gpio_loader_tick #(
    .CLK_DIV(CLK_DIV)
  ) u_tick (
    .i_clk      (mclk),
    .i_rst      (reset),
    .i_reload   (w_reload),
    .o_phase_end(w_phase_end)
  );

  always_comb begin
    w_next    = r_state;
    w_pad_nxt = r_pad;
    w_bit_nxt = r_bit;
    case (r_state)
      ST_IDLE: begin
        if (w_start) begin
          w_next    = ST_FETCH;
          w_pad_nxt = PAD_LAST;
        end
      end
      ST_FETCH:   w_next = ST_CAPTURE;
      ST_CAPTURE: begin
        w_next    = ST_SHIFT_LO;
        w_bit_nxt = BIT_LAST;
      end
      ST_SHIFT_LO: begin
        if (w_phase_end) w_next = ST_SHIFT_HI;
      end
      ST_SHIFT_HI: begin
        if (w_phase_end) begin
          if (r_bit != '0) begin
            w_next    = ST_SHIFT_LO;
            w_bit_nxt = r_bit - 1'b1;
          end else if (r_pad != '0) begin
            w_next    = ST_FETCH;
            w_pad_nxt = r_pad - 1'b1;
          end else begin
            w_next = ST_SETTLE;
          end
        end
      end
      ST_SETTLE: begin
        if (w_phase_end) w_next = ST_LOAD;
      end
      ST_LOAD: begin
        if (w_phase_end) w_next = ST_DONE;
      end
      ST_DONE: w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  assign w_reload   = (w_next != r_state);
  assign w_next_bit = (r_state == ST_SHIFT_HI) && (w_next == ST_SHIFT_LO);

  // Outputs are decoded from the next state so each one is a flop aligned with its state.
  always_ff @(posedge mclk) begin
    r_resetn <= ~reset;
    if (reset) begin
      r_state <= ST_IDLE;
      r_pad   <= '0;
      r_bit   <= '0;
      r_pend  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_rd_en <= 1'b0;
      r_addr  <= '0;
      r_sclk  <= 1'b0;
      r_sdat  <= 1'b0;
      r_load  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_pad   <= w_pad_nxt;
      r_bit   <= w_bit_nxt;
      r_pend  <= (r_state == ST_DONE) && start;
      r_busy  <= (w_next != ST_IDLE);
      r_done  <= (w_next == ST_DONE);
      r_rd_en <= (w_next == ST_FETCH);
      r_sclk  <= (w_next == ST_SHIFT_HI);
      r_load  <= (w_next == ST_LOAD);
      if (w_next == ST_FETCH) r_addr <= AW'(w_pad_nxt);
      if (r_state == ST_CAPTURE) r_sdat <= cfg_rd_data[MSB];
      else if (w_next_bit) r_sdat <= r_shift[MSB];
    end
  end

  // Holds the bits still to be sent; the MSB is already on serial_data_out.
  always_ff @(posedge mclk) begin
    if (r_state == ST_CAPTURE) r_shift <= cfg_rd_data << 1;
    else if (w_next_bit) r_shift <= r_shift << 1;
  end

  assign busy              = r_busy;
  assign done              = r_done;
  assign cfg_rd_en         = r_rd_en;
  assign cfg_rd_addr       = r_addr;
  assign serial_clock_out  = r_sclk;
  assign serial_data_out   = r_sdat;
  assign serial_load_out   = r_load;
  assign serial_resetn_out = r_resetn;

endmodule

// File: tb/tb_gpio_serial_loader.sv
// Directed bench: two loaders (CLK_DIV=2 and CLK_DIV=1), each feeding a model
// of a 15-pad chain that latches on load.
module tb_gpio_serial_loader;

  logic        mclk = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  start = 2'b00;
  logic [1:0]  busy, done, ren, sclk, sdat, load, rstn;
  logic [3:0]  addr [2];
  logic [11:0] rdata [2];

  int checks = 0;
  int failures = 0;
  int mode [2];

  logic [179:0] ch0, ch1;
  logic [11:0]  lat0 [15];
  logic [11:0]  lat1 [15];
  int nrise0 = 0, nrise1 = 0, nload0 = 0, nload1 = 0;

  always #5 mclk = ~mclk;

  gpio_serial_loader dut_a (
    .mclk(mclk), .reset(reset), .start(start[0]), .busy(busy[0]), .done(done[0]),
    .cfg_rd_en(ren[0]), .cfg_rd_addr(addr[0]), .cfg_rd_data(rdata[0]),
    .serial_clock_out(sclk[0]), .serial_data_out(sdat[0]),
    .serial_load_out(load[0]), .serial_resetn_out(rstn[0])
  );

  gpio_serial_loader #(.CLK_DIV(1)) dut_b (
    .mclk(mclk), .reset(reset), .start(start[1]), .busy(busy[1]), .done(done[1]),
    .cfg_rd_en(ren[1]), .cfg_rd_addr(addr[1]), .cfg_rd_data(rdata[1]),
    .serial_clock_out(sclk[1]), .serial_data_out(sdat[1]),
    .serial_load_out(load[1]), .serial_resetn_out(rstn[1])
  );

  function automatic logic [11:0] word(input int m, input logic [3:0] a);
    case (m)
      0:       return 12'hC00 ^ {8'h00, a};
      1:       return 12'hFFF;
      default: return 12'h000;
    endcase
  endfunction

  // Config port: data valid the cycle after the read strobe.
  always @(posedge mclk) begin
    if (ren[0]) rdata[0] <= word(mode[0], addr[0]);
    if (ren[1]) rdata[1] <= word(mode[1], addr[1]);
  end

  // Chain model: first bit shifted in ends at the top of the vector (pad 14 MSB).
  always @(posedge sclk[0]) begin
    ch0 <= {ch0[178:0], sdat[0]};
    nrise0 <= nrise0 + 1;
  end
  always @(posedge sclk[1]) begin
    ch1 <= {ch1[178:0], sdat[1]};
    nrise1 <= nrise1 + 1;
  end
  always @(posedge load[0]) begin
    for (int p = 0; p < 15; p++) lat0[p] <= ch0[p*12 +: 12];
    nload0 <= nload0 + 1;
  end
  always @(posedge load[1]) begin
    for (int p = 0; p < 15; p++) lat1[p] <= ch1[p*12 +: 12];
    nload1 <= nload1 + 1;
  end

  task automatic step();
    @(posedge mclk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic run_seq(input int k, input int inj, output int bc, output int nd,
                         output int lc, output int ov, output int himax, output int lomin,
                         output logic fren, output logic [3:0] faddr);
    int hi, lo, g;
    bc = 0; nd = 0; lc = 0; ov = 0; himax = 0; lomin = 1000; hi = 0; lo = 0; g = 0;
    start[k] = 1'b1;
    step();
    start[k] = 1'b0;
    fren  = ren[k];
    faddr = addr[k];
    while (busy[k] && g < 5000) begin
      bc++; g++;
      if (done[k]) nd++;
      if (load[k]) begin
        lc++;
        if (sclk[k]) ov++;
      end
      if (sclk[k]) begin
        if (hi == 0 && lo > 0 && lo < lomin) lomin = lo;
        hi++; lo = 0;
      end else begin
        if (hi > himax) himax = hi;
        hi = 0; lo++;
      end
      start[k] = (bc == inj);
      step();
    end
    start[k] = 1'b0;
  endtask

  task automatic wait_idle();
    int g;
    g = 0;
    while ((busy != 2'b00) && g < 5000) begin
      g++;
      step();
    end
    check("wait_idle", {30'd0, busy}, 32'd0);
  endtask

  initial begin
    int bc, nd, lc, ov, himax, lomin, r0, l0, g;
    logic fren;
    logic [3:0] faddr;

    mode[0] = 0;
    mode[1] = 1;
    repeat (3) step();
    check("rst_busy", busy[0], 1'b0);
    check("rst_done", done[0], 1'b0);
    check("rst_ren", ren[0], 1'b0);
    check("rst_addr", addr[0], 4'd0);
    check("rst_sclk", sclk[0], 1'b0);
    check("rst_sdat", sdat[0], 1'b0);
    check("rst_load", load[0], 1'b0);
    check("rst_resetn", rstn[0], 1'b0);

    reset = 1'b0;
`ifdef GPIO_LOADER_AUTOSTART_EN
    step();
    check("auto_ren_early", ren[0], 1'b0);
    step();
    check("auto_ren", ren[0], 1'b1);
    check("auto_addr", addr[0], 4'd14);
    check("auto_busy", busy[0], 1'b1);
    wait_idle();
    for (int p = 0; p < 15; p++) check($sformatf("auto_lat_a%0d", p), lat0[p], 12'hC00 ^ p);
    for (int p = 0; p < 15; p++) check($sformatf("auto_lat_b%0d", p), lat1[p], 12'hFFF);
`else
    repeat (4) step();
    check("idle_busy", busy[0], 1'b0);
    check("idle_ren", ren[0], 1'b0);
    check("idle_resetn", rstn[0], 1'b1);
`endif

    // Full load on the default loader with a stray start at cycle 100.
    r0 = nrise0; l0 = nload0;
    run_seq(0, 100, bc, nd, lc, ov, himax, lomin, fren, faddr);
    check("t1_first_ren", fren, 1'b1);
    check("t1_first_addr", faddr, 4'd14);
    check("t1_busy_len", bc, 755);
    check("t1_done_cnt", nd, 1);
    check("t1_rises", nrise0 - r0, 180);
    check("t1_loads", nload0 - l0, 1);
    check("t1_load_len", lc, 2);
    check("t1_load_ovl", ov, 0);
    check("t1_hi_len", himax, 2);
    check("t1_lo_len", lomin, 2);
    step();
    check("t1_idle_after", busy[0], 1'b0);
    for (int p = 0; p < 15; p++) check($sformatf("t1_lat%0d", p), lat0[p], 12'hC00 ^ p);

    // CLK_DIV=1 loader: all ones, then all zeros.
    mode[1] = 1;
    run_seq(1, 0, bc, nd, lc, ov, himax, lomin, fren, faddr);
    check("t2a_busy_len", bc, 393);
    for (int p = 0; p < 15; p++) check($sformatf("t2a_lat%0d", p), lat1[p], 12'hFFF);
    mode[1] = 2;
    r0 = nrise1;
    run_seq(1, 0, bc, nd, lc, ov, himax, lomin, fren, faddr);
    check("t2b_busy_len", bc, 393);
    check("t2b_rises", nrise1 - r0, 180);
    check("t2b_hi_len", himax, 1);
    check("t2b_lo_len", lomin, 1);
    check("t2b_load_len", lc, 1);
    for (int p = 0; p < 15; p++) check($sformatf("t2b_lat%0d", p), lat1[p], 12'h000);

    // Reset at cycle 400: no load, pads keep the previous configuration.
    mode[0] = 2;
    l0 = nload0;
    start[0] = 1'b1;
    step();
    start[0] = 1'b0;
    for (int n = 1; n < 400; n++) step();
    check("t4_busy_pre", busy[0], 1'b1);
    reset = 1'b1;
    step();
    check("t4_busy", busy[0], 1'b0);
    check("t4_sclk", sclk[0], 1'b0);
    check("t4_no_load", nload0 - l0, 0);
    for (int p = 0; p < 15; p++) check($sformatf("t4_lat%0d", p), lat0[p], 12'hC00 ^ p);
    reset = 1'b0;
    step();
`ifdef GPIO_LOADER_AUTOSTART_EN
    wait_idle();
`else
    repeat (3) step();
    check("t4_stays_idle", busy[0], 1'b0);
`endif

    // Start coincident with done is accepted; next fetch two cycles later.
    mode[0] = 0;
    start[0] = 1'b1;
    step();
    start[0] = 1'b0;
    g = 0;
    while (!done[0] && g < 2000) begin
      g++;
      step();
    end
    check("t5_done_seen", done[0], 1'b1);
    start[0] = 1'b1;
    step();
    start[0] = 1'b0;
    check("t5_gap_busy", busy[0], 1'b0);
    check("t5_gap_ren", ren[0], 1'b0);
    step();
    check("t5_ren", ren[0], 1'b1);
    check("t5_addr", addr[0], 4'd14);
    check("t5_busy", busy[0], 1'b1);
    wait_idle();
    for (int p = 0; p < 15; p++) check($sformatf("t5_lat%0d", p), lat0[p], 12'hC00 ^ p);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
